// File: rtl/reservoir_pkg.sv
// Shared types and default constants for the reservoir plant model and the controller bench.
package reservoir_pkg;

  typedef struct packed {
    logic fr2;
    logic fr1;
    logic fr0;
    logic dfr;
  } flow_vec_t;

  // Thermometer code, bit 2 is the highest sensor.
  typedef logic [2:0] sensor_t;

  localparam int unsigned DefLevelW    = 8;
  localparam int unsigned DefMaxLevel  = 200;
  localparam int unsigned DefS1Lvl     = 50;
  localparam int unsigned DefS2Lvl     = 100;
  localparam int unsigned DefS3Lvl     = 150;
  localparam int unsigned DefFlowUnit  = 4;
  localparam int unsigned DefTickDiv   = 4;
  localparam int unsigned DefInitLevel = 0;
  localparam int unsigned DefHyst      = 8;

  function automatic int unsigned flow_count(input flow_vec_t f);
    return 32'(f.fr2) + 32'(f.fr1) + 32'(f.fr0) + 32'(f.dfr);
  endfunction

endpackage

// File: rtl/level_sensor_cmp.sv
// Single level-sensor comparator; with RESERVOIR_SENSOR_HYST_EN defined it holds its state
// inside the band [THRESH-HYST, THRESH).
module level_sensor_cmp #(
  parameter int unsigned LEVEL_W = 8,
  parameter int unsigned THRESH  = 50,
  parameter int unsigned HYST    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               upd_i,
  input  logic [LEVEL_W-1:0] level_i,
  output logic               s_o
);

`ifdef RESERVOIR_SENSOR_HYST_EN
  localparam int ClrLvl = int'(THRESH) - int'(HYST);
`else
  // Clear level equal to the set level leaves no hold band: a plain compare.
  localparam int ClrLvl = int'(THRESH);
`endif

  logic s_d, s_q;

  always_comb begin
    s_d = s_q;
    if (upd_i) begin
      if (int'(level_i) >= int'(THRESH)) begin
        s_d = 1'b1;
      end else if (int'(level_i) < ClrLvl) begin
        s_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s_o = s_q;

endmodule

// File: rtl/reservoir_level_model.sv
// Reservoir plant model: integrates flow commands minus drain on a prescaled tick and
// drives the three level sensors. Optional sensor hysteresis: RESERVOIR_SENSOR_HYST_EN.
module reservoir_level_model
  import reservoir_pkg::*;
#(
  parameter int unsigned LEVEL_W    = DefLevelW,
  parameter int unsigned MAX_LEVEL  = DefMaxLevel,
  parameter int unsigned S1_LVL     = DefS1Lvl,
  parameter int unsigned S2_LVL     = DefS2Lvl,
  parameter int unsigned S3_LVL     = DefS3Lvl,
  parameter int unsigned FLOW_UNIT  = DefFlowUnit,
  parameter int unsigned TICK_DIV   = DefTickDiv,
  parameter int unsigned INIT_LEVEL = DefInitLevel,
  parameter int unsigned HYST       = DefHyst
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               fr2,
  input  logic               fr1,
  input  logic               fr0,
  input  logic               dfr,
  input  logic [3:0]         drain,
  input  logic               clr_flags,
  output logic [2:0]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               ovf_flag,
  output logic               dry_flag
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RawW = LEVEL_W + 3;
  localparam int unsigned Thresh [3] = '{S1_LVL, S2_LVL, S3_LVL};

  if (TICK_DIV < 1) begin : g_chk_div
    $error("TICK_DIV must be at least 1");
  end
  if (!(S1_LVL < S2_LVL && S2_LVL < S3_LVL)) begin : g_chk_thr
    $error("sensor thresholds must be strictly increasing");
  end
  if (INIT_LEVEL >= S1_LVL) begin : g_chk_init
    $error("INIT_LEVEL must be below S1_LVL");
  end
  if (MAX_LEVEL >= (1 << LEVEL_W)) begin : g_chk_max
    $error("MAX_LEVEL does not fit in LEVEL_W bits");
  end

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               dry_q, dry_d;
  flow_vec_t          flow;
  logic [RawW-1:0]    raw;
  logic               raw_neg;
  logic               raw_ovf;
  sensor_t            sense;

  assign flow = '{fr2: fr2, fr1: fr1, fr0: fr0, dfr: dfr};
  assign tick = en && (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  // Modulo-2^RawW arithmetic yields the two's-complement signed result; the MSB is the sign.
  assign raw     = RawW'(level_q) + RawW'(FLOW_UNIT * flow_count(flow)) - RawW'(drain);
  assign raw_neg = raw[RawW-1];
  assign raw_ovf = !raw_neg && (raw > RawW'(MAX_LEVEL));

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    dry_d   = dry_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      dry_d = 1'b0;
    end
    // Set conditions follow the clear so that set wins on a shared edge.
    if (tick) begin
      if (raw_ovf) begin
        level_d = LEVEL_W'(MAX_LEVEL);
        ovf_d   = 1'b1;
      end else if (raw_neg) begin
        level_d = '0;
        dry_d   = 1'b1;
      end else begin
        level_d = raw[LEVEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= LEVEL_W'(INIT_LEVEL);
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
    end
  end

  // Sensors see the post-update level so s and level change on the same edge.
  for (genvar i = 0; i < 3; i++) begin : g_sensor
    level_sensor_cmp #(
      .LEVEL_W(LEVEL_W),
      .THRESH (Thresh[i]),
      .HYST   (HYST)
    ) u_cmp (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .upd_i  (tick),
      .level_i(level_d),
      .s_o    (sense[i])
    );
  end

  assign s        = sense;
  assign level    = level_q;
  assign ovf_flag = ovf_q;
  assign dry_flag = dry_q;

endmodule
